// File: rtl/nes_pad_reader.sv
// +--------------------------------------------------------------------------+
// | nes_pad_reader: polls one NES pad over latch/clock/data and presents the |
// | 8 buttons as a registered active-high word. Option: NES_TWO_POLL_FILTER_EN|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module nes_pad_reader #(
  parameter int POLL_CYCLES  = 419583,
  parameter int LATCH_CYCLES = 302,
  parameter int HALF_CYCLES  = 151,
  parameter int CNT_W        = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_LOW   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] C_POLL_LAST  = CNT_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST  = CNT_W'(HALF_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       buttons_q, buttons_d;
  logic             valid_q, valid_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
`ifdef NES_TWO_POLL_FILTER_EN
  logic [7:0]       prev_raw_q, prev_raw_d;
`endif

  logic       poll_tick;
  logic       phase_done;
  logic       sample;
  logic [7:0] raw_word;

  assign poll_tick = (poll_cnt_q == C_POLL_LAST);
  assign raw_word  = ~shift_q;

  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      S_LATCH:               phase_done = (phase_cnt_q == C_LATCH_LAST);
      S_WAIT0, S_HIGH, S_LOW: phase_done = (phase_cnt_q == C_HALF_LAST);
      default:               phase_done = 1'b0;
    endcase
  end

  assign sample = phase_done && ((state_q == S_WAIT0) || (state_q == S_LOW));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a poll_tick outside IDLE is simply ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (poll_tick)  state_d = S_LATCH;
      S_LATCH: if (phase_done) state_d = S_WAIT0;
      S_WAIT0: if (phase_done) state_d = S_HIGH;
      S_HIGH:  if (phase_done) state_d = S_LOW;
      S_LOW:   if (phase_done) state_d = (bit_cnt_q == 3'd7) ? S_DONE : S_HIGH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    nes_latch = (state_q == S_LATCH);
    nes_clk   = (state_q == S_HIGH);
  end

  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;

  // Datapath
  always_comb begin
    sync1_d    = nes_data;
    sync2_d    = sync1_q;
    poll_cnt_d = poll_tick ? '0 : poll_cnt_q + 1'b1;
    phase_cnt_d = (phase_done || (state_q == S_IDLE) || (state_q == S_DONE))
                  ? '0 : phase_cnt_q + 1'b1;
    bit_cnt_d  = (state_q == S_IDLE) ? 3'd0 : bit_cnt_q;
    shift_d    = shift_q;
    buttons_d  = buttons_q;
    valid_d    = 1'b0;
`ifdef NES_TWO_POLL_FILTER_EN
    prev_raw_d = prev_raw_q;
`endif

    if (sample) begin
      shift_d[bit_cnt_q] = sync2_q;
      bit_cnt_d          = bit_cnt_q + 3'd1;
    end

    if (state_q == S_DONE) begin
`ifdef NES_TWO_POLL_FILTER_EN
      // Only a word seen on two consecutive polls is published
      prev_raw_d = raw_word;
      if (raw_word == prev_raw_q) begin
        buttons_d = raw_word;
        valid_d   = 1'b1;
      end
`else
      buttons_d = raw_word;
      valid_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      poll_cnt_q  <= '0;
      phase_cnt_q <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      buttons_q   <= 8'h00;
      valid_q     <= 1'b0;
`ifdef NES_TWO_POLL_FILTER_EN
      prev_raw_q  <= 8'h00;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      poll_cnt_q  <= poll_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      valid_q     <= valid_d;
`ifdef NES_TWO_POLL_FILTER_EN
      prev_raw_q  <= prev_raw_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural NES pad model.
`default_nettype none

module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       buttons_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  // Pad model: pad_word bit i is button i, 0 = pressed
  logic [7:0] pad_word = 8'hFF;
  logic [7:0] pad_sr   = 8'hFF;
  logic       pad_disc = 1'b1;
  logic       clk_seen = 1'b0;
  int         valid_cnt = 0;

  nes_pad_reader #(
    .POLL_CYCLES (200),
    .LATCH_CYCLES(8),
    .HALF_CYCLES (4),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .nes_data     (nes_data),
    .nes_latch    (nes_latch),
    .nes_clk      (nes_clk),
    .buttons      (buttons),
    .buttons_valid(buttons_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nes_latch) pad_sr <= pad_word;
    else if (nes_clk && !clk_seen) pad_sr <= {1'b1, pad_sr[7:1]};
    clk_seen <= nes_clk;
    if (buttons_valid) valid_cnt <= valid_cnt + 1;
  end

  assign nes_data = pad_disc ? 1'b1 : pad_sr[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    tick();
    tick();
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (buttons_valid) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_latch_rise(input int max, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (nes_latch) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit early;
    int hi;
    int n;
    bit ok;
    pad_disc = 1'b1;
    @(negedge clk) reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (nes_latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch: got %b want 0", nes_latch); end
    n_cmp++; if (nes_clk !== 1'b0) begin n_fail++; $display("FAIL reset_nes_clk: got %b want 0", nes_clk); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL reset_buttons: got %h want 00", buttons); end
    n_cmp++; if (buttons_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", buttons_valid); end
    @(negedge clk) reset = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 199; i++) begin
      tick();
      if (nes_latch) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL latch_early: got %b want 0", early); end
    tick();
    n_cmp++; if (nes_latch !== 1'b1) begin n_fail++; $display("FAIL latch_at_200: got %b want 1", nes_latch); end
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (nes_latch) hi++;
      else break;
    end
    n_cmp++; if (hi !== 8) begin n_fail++; $display("FAIL latch_width: got %0d want 8", hi); end
    wait_valid(100, n, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL first_valid_timeout: got %b want 1", ok); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL first_poll_buttons: got %h want 00", buttons); end
  endtask

  task automatic test_pattern();
    int n;
    bit ok;
    int pulses, bad_high, bad_low, run, vofs, vcycles;
    logic prev;
    logic [7:0] vbtn;
    pad_disc = 1'b0;
    pad_word = 8'h76;
    do_reset();
    wait_latch_rise(250, n, ok);
    n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL pattern_latch_rise: got %0d want 200", n); end
    pulses = 0; bad_high = 0; bad_low = 0; run = 1; vofs = -1; vcycles = 0;
    vbtn = 8'h00;
    prev = nes_clk;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (nes_clk === prev) begin
        run++;
      end else begin
        if (prev === 1'b1 && run != 4) bad_high++;
        if (prev === 1'b0 && pulses > 0 && run != 4) bad_low++;
        if (nes_clk === 1'b1) pulses++;
        run = 1;
      end
      prev = nes_clk;
      if (buttons_valid) begin
        vcycles++;
        if (vofs < 0) begin
          vofs = k;
          vbtn = buttons;
        end
      end
    end
    n_cmp++; if (pulses !== 7) begin n_fail++; $display("FAIL pattern_pulses: got %0d want 7", pulses); end
    n_cmp++; if (bad_high !== 0) begin n_fail++; $display("FAIL pattern_high_len: got %0d bad want 0", bad_high); end
    n_cmp++; if (bad_low !== 0) begin n_fail++; $display("FAIL pattern_low_len: got %0d bad want 0", bad_low); end
    n_cmp++; if (vofs !== 69) begin n_fail++; $display("FAIL pattern_valid_offset: got %0d want 69", vofs); end
    n_cmp++; if (vbtn !== 8'h89) begin n_fail++; $display("FAIL pattern_buttons: got %h want 89", vbtn); end
    n_cmp++; if (vcycles !== 1) begin n_fail++; $display("FAIL pattern_valid_width: got %0d want 1", vcycles); end
    n_cmp++; if (buttons !== 8'h89) begin n_fail++; $display("FAIL pattern_hold: got %h want 89", buttons); end
  endtask

  task automatic test_disconnected();
    int n;
    bit ok;
    pad_disc = 1'b1;
    wait_valid(250, n, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL disc_valid_timeout: got %b want 1", ok); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL disc_buttons: got %h want 00", buttons); end
    wait_valid(250, n, ok);
    n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL disc_valid_period: got %0d want 200", n); end
  endtask

  task automatic test_reset_midway();
    int n, rises, vbase;
    bit ok, early;
    logic prev;
    pad_disc = 1'b0;
    pad_word = 8'h76;
    wait_latch_rise(250, n, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_latch_timeout: got %b want 1", ok); end
    rises = 0;
    prev = nes_clk;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (nes_clk === 1'b1 && prev === 1'b0) rises++;
      prev = nes_clk;
      if (rises == 4) break;
    end
    n_cmp++; if (rises !== 4) begin n_fail++; $display("FAIL mid_fourth_high: got %0d want 4", rises); end
    tick();
    vbase = valid_cnt;
    @(negedge clk) reset = 1'b1;
    tick();
    n_cmp++; if (nes_clk !== 1'b0) begin n_fail++; $display("FAIL mid_reset_nes_clk: got %b want 0", nes_clk); end
    n_cmp++; if (nes_latch !== 1'b0) begin n_fail++; $display("FAIL mid_reset_latch: got %b want 0", nes_latch); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL mid_reset_buttons: got %h want 00", buttons); end
    @(negedge clk) reset = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 199; i++) begin
      tick();
      if (nes_latch) early = 1'b1;
    end
    n_cmp++; if (valid_cnt !== vbase) begin n_fail++; $display("FAIL mid_no_valid: got %0d pulses want 0", valid_cnt - vbase); end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL mid_latch_early: got %b want 0", early); end
    tick();
    n_cmp++; if (nes_latch !== 1'b1) begin n_fail++; $display("FAIL mid_latch_at_200: got %b want 1", nes_latch); end
    wait_valid(80, n, ok);
    n_cmp++; if (n !== 69) begin n_fail++; $display("FAIL mid_valid_offset: got %0d want 69", n); end
    n_cmp++; if (buttons !== 8'h89) begin n_fail++; $display("FAIL mid_buttons: got %h want 89", buttons); end
  endtask

  task automatic test_all_pressed();
    int n;
    bit ok;
    pad_disc = 1'b0;
    pad_word = 8'h00;
    wait_valid(250, n, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL all_valid_timeout: got %b want 1", ok); end
    n_cmp++; if (buttons !== 8'hFF) begin n_fail++; $display("FAIL all_pressed: got %h want FF", buttons); end
    pad_word = 8'hFF;
    wait_valid(250, n, ok);
    n_cmp++; if (n !== 200) begin n_fail++; $display("FAIL all_release_period: got %0d want 200", n); end
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL all_released: got %h want 00", buttons); end
  endtask

`ifdef NES_TWO_POLL_FILTER_EN
  task automatic wait_latch_fall(output bit ok);
    int n;
    wait_latch_rise(250, n, ok);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!nes_latch) break;
    end
  endtask

  task automatic test_filter();
    bit ok;
    int vbase;
    pad_disc = 1'b0;
    pad_word = 8'hFE;
    do_reset();
    vbase = valid_cnt;
    wait_latch_fall(ok);
    repeat (70) tick();
    n_cmp++; if (buttons !== 8'h00) begin n_fail++; $display("FAIL filter_first_poll: got %h want 00", buttons); end
    n_cmp++; if (valid_cnt !== vbase) begin n_fail++; $display("FAIL filter_first_valid: got %0d want 0", valid_cnt - vbase); end
    wait_latch_fall(ok);
    pad_word = 8'hFD;
    repeat (70) tick();
    n_cmp++; if (buttons !== 8'h01) begin n_fail++; $display("FAIL filter_second_poll: got %h want 01", buttons); end
    n_cmp++; if (valid_cnt !== vbase + 1) begin n_fail++; $display("FAIL filter_second_valid: got %0d want 1", valid_cnt - vbase); end
    wait_latch_fall(ok);
    pad_word = 8'hFE;
    wait_latch_fall(ok);
    pad_word = 8'hFD;
    wait_latch_fall(ok);
    repeat (70) tick();
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL filter_poll_timeout: got %b want 1", ok); end
    n_cmp++; if (buttons !== 8'h01) begin n_fail++; $display("FAIL filter_alternate: got %h want 01", buttons); end
    n_cmp++; if (valid_cnt !== vbase + 1) begin n_fail++; $display("FAIL filter_alt_valid: got %0d want 1", valid_cnt - vbase); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef NES_TWO_POLL_FILTER_EN
    test_filter();
`else
    test_pattern();
    test_disconnected();
    test_reset_midway();
    test_all_pressed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
